// File: rtl/data_sram_responder_pkg.sv
// Shared encodings and request-legality check for the data SRAM responder.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    localparam int STRB_W = 4;

    // Misaligned accesses, the reserved size and empty write strobes are protocol errors.
    function automatic logic req_illegal(input logic              wr,
                                         input logic [1:0]        size,
                                         input logic [1:0]        addr_lo,
                                         input logic [STRB_W-1:0] wstrb);
        size_e sz;
        sz = size_e'(size);
        return (sz == SZ_ILL)
             | ((sz == SZ_HALF) & addr_lo[0])
             | ((sz == SZ_WORD) & (addr_lo != 2'b00))
             | (wr & (wstrb == '0));
    endfunction

endpackage

// File: rtl/data_sram_responder_req_fifo.sv
// In-order queue of accepted requests; each entry counts down its own response latency.
module sram_req_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int DATA_LAT = 2,
    parameter int ENTRY_W  = 32
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [ENTRY_W-1:0]         i_push_data,
    input  logic                       i_pop,
    output logic                       o_head_due,
    output logic [ENTRY_W-1:0]         o_head,
    output logic [$clog2(QDEPTH):0]    o_count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int LAT_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(DATA_LAT - 1);

    logic [ENTRY_W-1:0] r_slot [QDEPTH];
    logic [LAT_W-1:0]   r_lat  [QDEPTH];
    logic [QDEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_vld[i] && (r_lat[i] != '0)) begin
                    r_lat[i] <= r_lat[i] - 1'b1;
                end
            end
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            // The caller never pushes into a full queue, so the push slot is never the popped one.
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_lat[r_wr_ptr] <= LAT_INIT;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_slot[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head     = r_slot[r_rd_ptr];
    assign o_head_due = r_vld[r_rd_ptr] & (r_lat[r_rd_ptr] == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data-memory slave: queued requests answered in order after a fixed latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int IDX_W       = 10,
    parameter int QDEPTH      = 4,
    parameter int DATA_LAT    = 2,
    parameter int ADDR_OK_GAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [31:0]       data_sram_addr,
    input  logic [STRB_W-1:0] data_sram_wstrb,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    output logic              err
);
    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam int GAP_W   = (ADDR_OK_GAP > 0) ? $clog2(ADDR_OK_GAP + 1) : 1;
    localparam int ENTRY_W = 1 + IDX_W + STRB_W + 32;

    logic [31:0]        r_mem [2**IDX_W];
    logic [GAP_W-1:0]   r_gap;
    logic               r_err;

    logic               w_accept;
    logic               w_head_due;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic               w_head_wr;
    logic [IDX_W-1:0]   w_head_idx;
    logic [STRB_W-1:0]  w_head_strb;
    logic [31:0]        w_head_wdata;
    logic               w_unused_addr_hi;

    // Address bits above the word index are dropped, so the memory aliases.
    assign w_unused_addr_hi = ^data_sram_addr[31:IDX_W+2];

    assign data_sram_addr_ok = ~reset & (w_count < CNT_W'(QDEPTH)) & (r_gap == '0);
    assign w_accept          = data_sram_req & data_sram_addr_ok;
    assign w_push_data       = {data_sram_wr, data_sram_addr[IDX_W+1:2], data_sram_wstrb, data_sram_wdata};

    sram_req_fifo #(
        .QDEPTH   (QDEPTH),
        .DATA_LAT (DATA_LAT),
        .ENTRY_W  (ENTRY_W)
    ) u_req_fifo (
        .clk         (clk),
        .i_rst       (reset),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (data_sram_data_ok),
        .o_head_due  (w_head_due),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign {w_head_wr, w_head_idx, w_head_strb, w_head_wdata} = w_head;

    assign data_sram_data_ok = ~reset & w_head_due;
    assign data_sram_rdata   = (data_sram_data_ok & ~w_head_wr) ? r_mem[w_head_idx] : 32'h0;
    assign err               = r_err;

    // Writes commit at their pop edge, so a younger read in the queue sees the new data.
    always_ff @(posedge clk) begin
        if (data_sram_data_ok && w_head_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_head_strb[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gap <= GAP_W'(ADDR_OK_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_accept && req_illegal(data_sram_wr, data_sram_size,
                                        data_sram_addr[1:0], data_sram_wstrb)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: three responder configurations share one stimulus, each checked in its own test.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;

    logic        a_aok, a_dok, a_err;
    logic [31:0] a_rd;
    logic        b_aok, b_dok, b_err;
    logic [31:0] b_rd;
    logic        c_aok, c_dok, c_err;
    logic [31:0] c_rd;

    always #5 clk = ~clk;

    data_sram_responder #(.IDX_W(10), .QDEPTH(4), .DATA_LAT(2), .ADDR_OK_GAP(0)) u_a (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(strb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(a_aok), .data_sram_data_ok(a_dok),
        .data_sram_rdata(a_rd), .err(a_err));

    data_sram_responder #(.IDX_W(10), .QDEPTH(4), .DATA_LAT(8), .ADDR_OK_GAP(0)) u_b (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(strb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(b_aok), .data_sram_data_ok(b_dok),
        .data_sram_rdata(b_rd), .err(b_err));

    data_sram_responder #(.IDX_W(10), .QDEPTH(4), .DATA_LAT(2), .ADDR_OK_GAP(2)) u_c (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(strb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(c_aok), .data_sram_data_ok(c_dok),
        .data_sram_rdata(c_rd), .err(c_err));

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [13];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   accepts, k, seen;
    logic exp_aok, exp_dok;

    function automatic vec_t v(input logic r, input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                               input logic ea, input logic ed, input logic [31:0] er);
        vec_t t;
        t.req = r; t.wr = w; t.size = s; t.addr = a; t.strb = st; t.wdata = d;
        t.aok = ea; t.dok = ed; t.rdata = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
        req = r; wr = w; size = s; addr = a; strb = st; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        tbl[0]  = v(1, 1, 2, 32'h10,   4'hF, 32'hDEADBEEF, 1, 0, 32'h0);
        tbl[1]  = v(1, 0, 2, 32'h10,   4'h0, 32'h0,        1, 0, 32'h0);
        tbl[2]  = v(1, 1, 2, 32'h20,   4'hF, 32'h11223344, 1, 1, 32'h0);
        tbl[3]  = v(1, 1, 0, 32'h22,   4'h4, 32'hAAAAAAAA, 1, 1, 32'hDEADBEEF);
        tbl[4]  = v(1, 0, 2, 32'h20,   4'h0, 32'h0,        1, 1, 32'h0);
        tbl[5]  = v(0, 0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h0);
        tbl[6]  = v(0, 0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h11AA3344);
        tbl[7]  = v(1, 0, 2, 32'h1010, 4'h0, 32'h0,        1, 0, 32'h0);
        tbl[8]  = v(1, 1, 1, 32'h12,   4'hC, 32'h55665566, 1, 0, 32'h0);
        tbl[9]  = v(1, 0, 2, 32'h10,   4'h0, 32'h0,        1, 1, 32'hDEADBEEF);
        tbl[10] = v(0, 0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h0);
        tbl[11] = v(0, 0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h5566BEEF);
        tbl[12] = v(0, 0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aok", {31'b0, a_aok}, 32'h0);
        chk("rst_dok", {31'b0, a_dok}, 32'h0);
        chk("rst_rdata", a_rd, 32'h0);
        chk("rst_err", {31'b0, a_err}, 32'h0);
        chk("rst_aok_b", {31'b0, b_aok}, 32'h0);
        reset = 1'b0;
        #1 chk("rel_aok", {31'b0, a_aok}, 32'h1);
        tick();

        // Write/read, byte and half strobes, aliasing on the default configuration
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drv(tbl[i].req, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].strb, tbl[i].wdata);
            #1;
            chk($sformatf("vec%0d_aok", i), {31'b0, a_aok}, {31'b0, tbl[i].aok});
            chk($sformatf("vec%0d_dok", i), {31'b0, a_dok}, {31'b0, tbl[i].dok});
            chk($sformatf("vec%0d_rdata", i), a_rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, a_err}, 32'h0);
            tick();
        end

        // Reset mid-traffic drops outstanding reads
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 2, 32'h20, 4'h0, 32'h0);
            #1 chk($sformatf("mid_aok%0d", i), {31'b0, b_aok}, 32'h1);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_dok", {31'b0, b_dok}, 32'h0);
        chk("mid_rst_aok", {31'b0, b_aok}, 32'h0);
        chk("mid_rst_rdata", b_rd, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1 chk("mid_rel_aok", {31'b0, b_aok}, 32'h1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b_dok) seen++;
        end
        chk("mid_no_dok", seen, 0);

        // Backpressure with DATA_LAT=8
        do_reset();
        accepts = 0;
        for (int c = 0; c < 14; c++) begin
            drv(c < 6, 0, 2, 32'h40, 4'h0, 32'h0);
            #1;
            exp_aok = (c < 4) || (c >= 9);
            exp_dok = (c >= 8) && (c <= 11);
            chk($sformatf("bp%0d_aok", c), {31'b0, b_aok}, {31'b0, exp_aok});
            chk($sformatf("bp%0d_dok", c), {31'b0, b_dok}, {31'b0, exp_dok});
            if (req && b_aok) accepts++;
            tick();
        end
        chk("bp_accepts", accepts, 4);
        chk("bp_err", {31'b0, b_err}, 32'h0);

        // ADDR_OK_GAP=2: four writes then four reads, spaced three cycles apart
        do_reset();
        k = 0;
        for (int c = 0; c < 26; c++) begin
            drv(k < 8, k < 4, 2, 32'h100 + 32'(4 * (k % 4)), 4'hF, 32'hC0DE0000 + 32'(k));
            #1;
            exp_aok = (c <= 21) ? (c % 3 == 0) : (c >= 24);
            exp_dok = (c % 3 == 2) && (c <= 23);
            chk($sformatf("gap%0d_aok", c), {31'b0, c_aok}, {31'b0, exp_aok});
            chk($sformatf("gap%0d_dok", c), {31'b0, c_dok}, {31'b0, exp_dok});
            if (exp_dok)
                chk($sformatf("gap%0d_rdata", c), c_rd,
                    (c >= 14) ? 32'hC0DE0000 + 32'((c - 14) / 3) : 32'h0);
            if (req && c_aok) k++;
            tick();
        end
        chk("gap_err", {31'b0, c_err}, 32'h0);

        // Error flag: misaligned word read, then empty-strobe write
        do_reset();
        drv(1, 0, 2, 32'h6, 4'h0, 32'h0);
        #1;
        chk("err_pre", {31'b0, a_err}, 32'h0);
        chk("err_aok", {31'b0, a_aok}, 32'h1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #1 chk("err_set", {31'b0, a_err}, 32'h1);
        tick();
        #1 chk("err_dok", {31'b0, a_dok}, 32'h1);
        repeat (4) tick();
        chk("err_hold", {31'b0, a_err}, 32'h1);
        do_reset();
        #1 chk("err_clr", {31'b0, a_err}, 32'h0);
        drv(1, 1, 2, 32'h30, 4'h0, 32'h12345678);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #1 chk("err_strb0", {31'b0, a_err}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
